// File: rtl/multi_state_monitor_pkg.sv
// ----------------------------------------------------------------------------
// multi_state_monitor_pkg
// Shared types and elaboration-time helpers for the multi-channel transient
// monitor.
//   state_t      : per-channel FSM encoding (ST_IDLE = 0, ST_HOLD = 1)
//   clog2_min1() : ceil(log2(n)), never less than 1 (select port width)
//   cnt_w_ok()   : true when the largest hold-off load fits in the counter
// ----------------------------------------------------------------------------
package multi_state_monitor_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // Largest load is (2^compare_w - 1) * scale; it must be representable
    // in cnt_w bits or long hold-offs would silently wrap.
    function automatic bit cnt_w_ok(input int compare_w, input int scale,
                                    input int cnt_w);
        longint max_load;
        max_load = ((longint'(1) << compare_w) - 1) * longint'(scale);
        return (cnt_w > 0) && (cnt_w < 63) && (max_load < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/multi_state_monitor_channel.sv
// ----------------------------------------------------------------------------
// state_monitor_channel
// One monitored line: synchroniser, invalid-edge detector, IDLE/HOLD FSM with
// retriggerable hold-off counter, sticky fault flag and saturating event count.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_signal         raw asynchronous line
//   i_polarity       0 = rising edge invalid, 1 = falling edge invalid
//   i_enable         channel enable; low forces IDLE and suppresses events
//   i_hold_load      hold-off length in cycles (shared, precomputed)
//   i_clear          clears fault and event count
//   o_valid          1 = not in hold-off (registered)
//   o_fault          sticky invalid-edge flag
//   o_evt_cnt        saturating invalid-edge count
// ----------------------------------------------------------------------------
module state_monitor_channel
    import multi_state_monitor_pkg::*;
#(
    parameter int CNT_W       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int EVT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_signal,
    input  logic             i_polarity,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_hold_load,
    input  logic             i_clear,
    output logic             o_valid,
    output logic             o_fault,
    output logic [EVT_W-1:0] o_evt_cnt
);

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("state_monitor_channel: SYNC_STAGES must be >= 2");
    end

    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic                   r_valid;
    logic                   r_fault;
    logic [EVT_W-1:0]       r_evt;

    logic w_s;
    logic w_inv;

    assign w_s   = r_sync[SYNC_STAGES-1];
    // Invalid edge: a change whose new level is the opposite of the polarity bit.
    assign w_inv = i_enable & (w_s ^ r_prev) & (w_s == ~i_polarity);

    // NOTE: reset is sampled on the clock edge, so every register, including
    // the synchroniser, sits inside the reset branch of one clocked block.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_state <= ST_IDLE;
            r_count <= '0;
            r_valid <= 1'b1;
            r_fault <= 1'b0;
            r_evt   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees the
            // previous-cycle values regardless of statement order.
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
            // Prev keeps tracking while disabled so re-enabling sees no false edge.
            r_prev <= w_s;

            if (!i_enable) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b1;
                r_count <= i_hold_load;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_count <= i_hold_load;
                        if (w_inv) begin
                            r_state <= ST_HOLD;
                            r_valid <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (w_inv) begin
                            r_count <= i_hold_load;
                        end else if (r_count == '0) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b1;
                        end else begin
                            r_count <= r_count - CNT_W'(1);
                        end
                    end
                endcase
            end

            // Set wins over a simultaneous clear.
            if (w_inv)        r_fault <= 1'b1;
            else if (i_clear) r_fault <= 1'b0;

            // Clear and event together leave a count of one.
            if (i_clear)                      r_evt <= w_inv ? EVT_W'(1) : '0;
            else if (w_inv && r_evt != EVT_MAX) r_evt <= r_evt + EVT_W'(1);
        end
    end

    assign o_valid   = r_valid;
    assign o_fault   = r_fault;
    assign o_evt_cnt = r_evt;

endmodule

// File: rtl/multi_state_monitor.sv
// ----------------------------------------------------------------------------
// multi_state_monitor
// N-channel transient monitor. Each channel drops its valid flag for a
// programmable, retriggerable hold-off after an invalid-direction edge.
// Note: s/p reset to 0, so a line held high with polarity 0 yields one
// detected edge after reset release; this is intentional and not masked.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_signal         N_CH asynchronous monitored lines
//   i_polarity       per-channel invalid-edge select
//   i_enable         per-channel enable
//   i_compare        shared hold-off length in SCALE units
//   i_clear          per-channel fault/event-count clear
//   i_sel            channel select for o_evt_cnt
//   o_valid          per-channel valid (registered)
//   o_fault          per-channel sticky fault
//   o_all_valid      AND of o_valid over enabled channels
//   o_evt_cnt        event count of channel i_sel
// ----------------------------------------------------------------------------
module multi_state_monitor
    import multi_state_monitor_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int COMPARE_W   = 4,
    parameter int SCALE       = 10000,
    parameter int CNT_W       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int EVT_W       = 8,
    localparam int SEL_W      = clog2_min1(N_CH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_CH-1:0]      i_signal,
    input  logic [N_CH-1:0]      i_polarity,
    input  logic [N_CH-1:0]      i_enable,
    input  logic [COMPARE_W-1:0] i_compare,
    input  logic [N_CH-1:0]      i_clear,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [N_CH-1:0]      o_valid,
    output logic [N_CH-1:0]      o_fault,
    output logic                 o_all_valid,
    output logic [EVT_W-1:0]     o_evt_cnt
);

    if (!cnt_w_ok(COMPARE_W, SCALE, CNT_W)) begin : g_cnt_w_check
        $error("multi_state_monitor: CNT_W too small for (2^COMPARE_W-1)*SCALE");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_n_ch_check
        $error("multi_state_monitor: N_CH must be in 1..8");
    end

    // Shared load value, truncated to the counter width.
    logic [CNT_W-1:0] w_hold_load;
    assign w_hold_load = CNT_W'(i_compare) * CNT_W'(SCALE);

    logic [EVT_W-1:0] w_evt [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_monitor_channel #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .EVT_W      (EVT_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_signal   (i_signal[g]),
            .i_polarity (i_polarity[g]),
            .i_enable   (i_enable[g]),
            .i_hold_load(w_hold_load),
            .i_clear    (i_clear[g]),
            .o_valid    (o_valid[g]),
            .o_fault    (o_fault[g]),
            .o_evt_cnt  (w_evt[g])
        );
    end

    // Disabled channels count as valid, so no enables gives 1.
    assign o_all_valid = &(o_valid | ~i_enable);

    // NOTE: default assignment first so the mux cannot infer a latch.
    always_comb begin
        o_evt_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (i_sel == SEL_W'(i)) o_evt_cnt = w_evt[i];
        end
    end

endmodule

// File: doc/multi_state_monitor.md
Name: multi_state_monitor

Overview:
N-channel transient monitor. Each channel watches one asynchronous digital line. When the line makes an edge of the "invalid" direction, the channel drops its valid flag for a programmable hold-off time. This generalises the single-channel state monitor with:
- per-channel polarity and enable
- input synchronisation
- retriggerable hold-off
- sticky fault flags
- per-channel event counters readable through a channel select
- an aggregate valid output
Sits between the tile's raw input pins and the status/output logic.

Parameters:
N_CH, 4, number of monitored channels (1..8)
COMPARE_W, 4, width of the shared hold-off select
SCALE, 10000, clock cycles per hold-off unit (10 kHz clock -> 1 s per unit)
CNT_W, 18, hold-off counter width; elaboration error unless (2^COMPARE_W-1)*SCALE < 2^CNT_W
SYNC_STAGES, 2, synchroniser flops per input (>=2)
EVT_W, 8, per-channel event counter width

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous reset, active high
i_signal  in  N_CH  monitored lines, asynchronous
i_polarity  in  N_CH  per-channel invalid-edge select: 0 = rising edge invalid, 1 = falling edge invalid
i_enable  in  N_CH  per-channel enable
i_compare  in  COMPARE_W  shared hold-off length in SCALE units
i_clear  in  N_CH  per-channel pulse; clears fault and event count
i_sel  in  clog2(N_CH) (min 1)  channel select for o_evt_cnt
o_valid  out  N_CH  1 = channel stable / not in hold-off
o_fault  out  N_CH  sticky invalid-edge flag
o_all_valid  out  1  AND of o_valid over enabled channels; 1 if none enabled
o_evt_cnt  out  EVT_W  event count of channel i_sel (combinational mux)

Behaviour:
- Reset values:
  - sync chain, prev register, counters, o_fault, event counts: 0
  - state: IDLE
  - o_valid: all 1
  - o_all_valid: 1
- Synchronisation and edge detect per channel:
  - s = last synchroniser stage; p = s delayed one cycle.
  - inv = enable & (s != p) & (s == ~polarity).
- States per channel (2 states):
  - IDLE: valid=1; counter <= i_compare*SCALE every cycle (product truncated to CNT_W); inv -> HOLD.
  - HOLD: valid=0.
    - inv -> stay in HOLD, counter <= i_compare*SCALE (retrigger).
    - else counter==0 -> IDLE.
    - else counter <= counter-1.
- Hold length: a single invalid edge gives exactly i_compare*SCALE+1 cycles of valid=0; i_compare=0 gives 1 cycle.
- Latency: input change captured by the first sync flop at edge 0 -> o_valid low from edge SYNC_STAGES.
- o_valid is registered (decoded from the state register). o_all_valid is combinational from registered state.
- i_compare is sampled every IDLE cycle. Changes during HOLD affect only retriggers.
- Disable:
  - i_enable=0 forces IDLE next cycle (aborts HOLD) and suppresses inv.
  - Sync chain and p keep tracking, so re-enabling does not create a false edge.
  - Fault and event count hold their values.
- Fault: inv sets o_fault the next cycle. i_clear clears it. Set wins over a simultaneous clear.
- Event count:
  - Increments on every inv (including retriggers) and saturates at 2^EVT_W-1.
  - i_clear zeroes it. A simultaneous inv+clear yields 1.
- Post-reset artefact (required, documented): s and p reset to 0. A line held high with polarity=0 produces one detected edge after reset release. This is not masked.
- Mid-operation reset: all channels return to reset values on the next edge regardless of state.
- Non-invalid-direction edges have no effect in either state.

Decomposition:
- Package multi_state_monitor_pkg:
  - state encoding constants ST_IDLE=0, ST_HOLD=1
  - CNT_W legality check function
  - clog2 helper
- Sub-module state_monitor_channel: one channel's sync chain, edge detect, FSM, hold counter, fault and event counter.
- The top generates N_CH instances, computes the shared i_compare*SCALE product once, and builds the o_all_valid reduction and o_evt_cnt mux.

Test Plan (N_CH=4, SCALE=4, COMPARE_W=4, CNT_W=8, SYNC_STAGES=2, EVT_W=4):
- Reset, all lines 0, all enabled, polarity 0 -> o_valid=4'b1111, o_fault=0, o_all_valid=1, o_evt_cnt=0 for every i_sel.
- i_compare=3, ch0 rises at edge 0 -> o_valid[0] low from edge 2 for exactly 13 cycles; o_fault[0]=1; evt_cnt[0]=1; other channels unaffected.
- Ch1 with polarity 1: rising edge -> no response; falling edge -> hold. Second falling edge 5 cycles into the hold restarts the 12-count; evt_cnt[1]=2.
- Ch2 disabled mid-HOLD -> o_valid[2]=1 next cycle; o_all_valid ignores ch2. Re-enable with line static -> no event.
- i_clear[0] on the same cycle as a new ch0 invalid edge -> o_fault[0]=1, evt_cnt[0]=1. 20 further edges -> evt_cnt saturates at 15.
- i_compare=0 -> 1-cycle valid drop. Assert i_reset during a hold -> all outputs return to reset values on the next edge.
